// File: rtl/capacitor_charge_discharge_stage_pkg.sv
// discrete_pkg: shared types, widths and the RC alpha helper for the discrete analog stages.
package discrete_pkg;

    localparam int ALPHA_W = 16;

    typedef enum logic [1:0] {IDLE, MULT, UPDATE} cap_state_t;

    // alpha = 2^32*1e6 / (2^16*1e6 + R*C_16*fs), clamped to [1, 65535]
    function automatic logic [ALPHA_W-1:0] calc_rc_alpha(
        input longint unsigned r,
        input longint unsigned c_16,
        input longint unsigned sample_rate
    );
        longint unsigned q;
        q = (64'd4294967296 * 64'd1000000) / (64'd65536 * 64'd1000000 + r * c_16 * sample_rate);
        return (q == 64'd0) ? 16'd1 : (q > 64'd65535) ? 16'hffff : q[15:0];
    endfunction

endpackage

// File: rtl/capacitor_charge_discharge_stage_if.sv
// capacitor_charge_discharge_stage_if: sample strobe, input voltage and shaped capacitor voltage.
interface capacitor_charge_discharge_stage_if;
    logic               audio_clk_en;
    logic signed [15:0] in;
    logic signed [15:0] out;
    logic               charging;

    modport master(output audio_clk_en, output in, input out, input charging);
    modport slave(input audio_clk_en, input in, output out, output charging);
endinterface

// File: rtl/capacitor_charge_discharge_stage_serial_shift_add_multiplier.sv
// serial_shift_add_multiplier: 17-bit signed x 16-bit unsigned product, one partial product per cycle.
import discrete_pkg::*;

module serial_shift_add_multiplier (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic signed [16:0]        a,
    input  logic        [ALPHA_W-1:0] b,
    output logic signed [33:0]        acc,
    output logic                      done
);
    logic signed [16:0]        a_q;
    logic        [ALPHA_W-1:0] b_q;
    logic        [3:0]         k;
    logic                      busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
            k    <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                a_q  <= a;
                b_q  <= b;
                acc  <= '0;
                k    <= '0;
                busy <= 1'b1;
            end else if (busy) begin
                if (b_q[k])
                    acc <= acc + (34'(a_q) <<< k);
                k <= k + 4'd1;
                if (k == 4'd15) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/capacitor_charge_discharge_stage.sv
// capacitor_charge_discharge_stage: per-sample RC approach of out toward in with separate charge/discharge alpha.
// Define CAP_STAGE_SNAP_EN to force a +/-1 step when the rounded step is zero, so out converges exactly.
import discrete_pkg::*;

module capacitor_charge_discharge_stage #(
    parameter int CLOCK_RATE               = 50000000,
    parameter int SAMPLE_RATE              = 48000,
    parameter int R_CHARGE                 = 1000,
    parameter int R_DISCHARGE              = 10000,
    parameter int C_MICROFARADS_16_SHIFTED = 655360
) (
    input logic clk,
    input logic reset,
    capacitor_charge_discharge_stage_if.slave bus
);
    localparam logic [ALPHA_W-1:0] ALPHA_CHARGE    = calc_rc_alpha(R_CHARGE, C_MICROFARADS_16_SHIFTED, SAMPLE_RATE);
    localparam logic [ALPHA_W-1:0] ALPHA_DISCHARGE = calc_rc_alpha(R_DISCHARGE, C_MICROFARADS_16_SHIFTED, SAMPLE_RATE);

    if (CLOCK_RATE / SAMPLE_RATE < 20) begin : g_rate_check
        $error("CLOCK_RATE/SAMPLE_RATE must be at least 20");
    end

    cap_state_t                state, state_nx;
    logic                      armed, pending, charging_q, strobe, start, done;
    logic signed [15:0]        in_q, out_q, src, base, out_upd;
    logic signed [16:0]        diff_q, diff_nx;
    logic signed [17:0]        step_raw, step;
    logic signed [33:0]        acc;
    logic        [ALPHA_W-1:0] alpha_nx;

    // armed blocks a strobe arriving on the first edge after reset release
    assign strobe   = bus.audio_clk_en & armed;
    assign step_raw = 18'((acc + 34'sd32768) >>> 16);
`ifdef CAP_STAGE_SNAP_EN
    assign step     = (step_raw == 18'sd0 && diff_q != 17'sd0) ? (diff_q[16] ? -18'sd1 : 18'sd1) : step_raw;
`else
    assign step     = step_raw;
`endif
    assign out_upd  = 16'(out_q + step);
    assign diff_nx  = 17'(src) - 17'(base);
    assign alpha_nx = (diff_nx > 17'sd0) ? ALPHA_CHARGE : ALPHA_DISCHARGE;

    // a queued request is chained from UPDATE against the freshly updated out
    always_comb begin
        start    = (state == IDLE) ? strobe : (state == UPDATE) ? (pending | strobe) : 1'b0;
        src      = (state == UPDATE && !strobe) ? in_q : bus.in;
        base     = (state == UPDATE) ? out_upd : out_q;
        state_nx = start ? MULT : (state == MULT) ? (done ? UPDATE : MULT) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed      <= 1'b0;
            pending    <= 1'b0;
            in_q       <= '0;
            out_q      <= '0;
            diff_q     <= '0;
            charging_q <= 1'b0;
        end else begin
            armed   <= 1'b1;
            pending <= (state == MULT) & (pending | strobe);
            if (strobe)
                in_q <= bus.in;
            if (start)
                diff_q <= diff_nx;
            if (state == UPDATE) begin
                out_q      <= out_upd;
                charging_q <= diff_q > 17'sd0;
            end
        end
    end

    serial_shift_add_multiplier u_mult (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (diff_nx),
        .b     (alpha_nx),
        .acc   (acc),
        .done  (done)
    );

    assign bus.out      = out_q;
    assign bus.charging = charging_q;
endmodule

// File: tb/tb_capacitor_charge_discharge_stage.sv
// tb_capacitor_charge_discharge_stage: directed checks of latency, RC curves, pending, reset and diff==0.
module tb_capacitor_charge_discharge_stage;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   m;
    int   prev;
    int   nonmono;

    capacitor_charge_discharge_stage_if bus();

    capacitor_charge_discharge_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // alpha values hand-derived: 136 for 1k/10uF, 13 for 10k/10uF at 48 kHz
    function automatic int model_next(input int o, input int i);
        int     d;
        int     s;
        longint p;
        d = i - o;
        p = longint'(d) * ((d > 0) ? 136 : 13);
        s = int'((p + 32768) >>> 16);
`ifdef CAP_STAGE_SNAP_EN
        if (s == 0 && d != 0)
            s = (d > 0) ? 1 : -1;
`endif
        return o + s;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic strobe(input int v);
        bus.audio_clk_en = 1'b1;
        bus.in = 16'(v);
        @(negedge clk);
        bus.audio_clk_en = 1'b0;
    endtask

    task automatic sample(input int v);
        strobe(v);
        repeat (18) @(negedge clk);
        m = model_next(m, v);
    endtask

    initial begin
        bus.audio_clk_en = 1'b0;
        bus.in = '0;
        @(negedge clk);
        do_reset();
        check("reset_out", bus.out, 0);
        check("reset_charging", bus.charging, 0);

        strobe(16384);
        repeat (17) @(negedge clk);
        check("s1_before", bus.out, 0);
        @(negedge clk);
        check("s1_out", bus.out, 34);
        check("s1_charging", bus.charging, 1);

        strobe(16384);
        repeat (7) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("s5_out_async", bus.out, 0);
        check("s5_charging_async", bus.charging, 0);
        @(negedge clk);
        reset = 1'b0;
        strobe(16384);
        repeat (20) @(negedge clk);
        check("s5_ignored_strobe", bus.out, 0);
        strobe(16384);
        repeat (17) @(negedge clk);
        check("s5_before", bus.out, 0);
        @(negedge clk);
        check("s5_out", bus.out, 34);
        check("s5_charging", bus.charging, 1);

        do_reset();
        strobe(16384);
        repeat (4) @(negedge clk);
        strobe(-16384);
        repeat (12) @(negedge clk);
        check("s4_before", bus.out, 0);
        @(negedge clk);
        check("s4_first", bus.out, 34);
        check("s4_first_charging", bus.charging, 1);
        repeat (17) @(negedge clk);
        check("s4_hold", bus.out, 34);
        @(negedge clk);
        check("s4_second", bus.out, 31);
        check("s4_second_charging", bus.charging, 0);

        do_reset();
        m = 0;
        prev = 0;
        nonmono = 0;
        for (int n = 1; n <= 2500; n++) begin
            sample(16384);
            check("s2_curve", bus.out, m);
            if (int'(bus.out) < prev)
                nonmono++;
            prev = bus.out;
            if (n == 480)
                check("s2_tau_2pct", int'(bus.out >= 16'sd10149 && bus.out <= 16'sd10563), 1);
        end
        check("s2_monotonic", nonmono, 0);
`ifdef CAP_STAGE_SNAP_EN
        check("s2_final", bus.out, 16384);
`else
        check("s2_stall_range", int'(bus.out >= 16'sd16143), 1);
`endif

        sample(0);
        check("s3_first", bus.out, m);
        check("s3_charging", bus.charging, 0);
`ifdef CAP_STAGE_SNAP_EN
        check("s3_first_abs", bus.out, 16381);
`endif
        for (int n = 2; n <= 1000; n++) begin
            sample(0);
            check("s3_curve", bus.out, m);
        end

        sample(16384);
        check("s6_pre_charging", bus.charging, 1);
        prev = m;
        sample(prev);
        check("s6_out_unchanged", bus.out, prev);
        check("s6_charging", bus.charging, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
